// File: rtl/dispensador_troco.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// dispensador_troco
// Change dispenser placed after the vending-machine controller. On a request
// it snapshots the amount owed and the coin stock, then ejects coins one per
// SELECT/EJECT pair, always the largest denomination that still fits the
// remaining amount and is in stock. Selection is greedy with no backtracking.
//
// Ports
//   clock              system clock, rising edge
//   reset              asynchronous, active-high reset
//   dar_troco          change request, sampled only while idle
//   valor_troco[7:0]   amount owed, latched with dar_troco
//   moedas_carteira    six 4-bit coin counts, field k = [4k+3:4k], latched
//   ejeta_moeda        one-cycle pulse per ejected coin
//   tipo_moeda[2:0]    denomination index of the ejected coin
//   moedas_devolvidas  per-denomination tally of coins ejected this transaction
//   valor_pendente     amount still owed
//   ocupado            high from acceptance until the completion cycle ends
//   troco_pronto       one-cycle completion pulse
//   troco_ok           last transaction fully paid (held)
//   troco_falha        last transaction short (held)
// -----------------------------------------------------------------------------
module dispensador_troco #(
  parameter logic [7:0] V5 = 8'd100,
  parameter logic [7:0] V4 = 8'd50,
  parameter logic [7:0] V3 = 8'd25,
  parameter logic [7:0] V2 = 8'd10,
  parameter logic [7:0] V1 = 8'd5,
  parameter logic [7:0] V0 = 8'd1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        dar_troco,
  input  logic [7:0]  valor_troco,
  input  logic [23:0] moedas_carteira,
  output logic        ejeta_moeda,
  output logic [2:0]  tipo_moeda,
  output logic [23:0] moedas_devolvidas,
  output logic [7:0]  valor_pendente,
  output logic        ocupado,
  output logic        troco_pronto,
  output logic        troco_ok,
  output logic        troco_falha
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SELECT = 2'd1,
    S_EJECT  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        ejeta_q, ejeta_d;
  logic [2:0]  tipo_q, tipo_d;
  logic [23:0] devol_q, devol_d;
  logic [7:0]  pend_q, pend_d;
  logic        ocup_q, ocup_d;
  logic        pronto_q, pronto_d;
  logic        ok_q, ok_d;
  logic        falha_q, falha_d;
  logic [23:0] stock_q, stock_d;

  logic        sel_found_s;
  logic [2:0]  sel_idx_s;

  // Value of denomination k; out-of-range indices map to 0 so they never fit.
  function automatic logic [7:0] coin_value(input logic [2:0] k);
    logic [7:0] v;
    case (k)
      3'd0:    v = V0;
      3'd1:    v = V1;
      3'd2:    v = V2;
      3'd3:    v = V3;
      3'd4:    v = V4;
      3'd5:    v = V5;
      default: v = 8'd0;
    endcase
    return v;
  endfunction

  // Increment or decrement one 4-bit field of a six-field count vector.
  function automatic logic [23:0] field_step(input logic [23:0] v,
                                             input logic [2:0]  idx,
                                             input logic        inc);
    logic [23:0] r;
    r = v;
    for (int k = 0; k < 6; k++) begin
      if (3'(k) == idx) begin
        r[4*k +: 4] = inc ? (v[4*k +: 4] + 4'd1) : (v[4*k +: 4] - 4'd1);
      end else begin
        r[4*k +: 4] = v[4*k +: 4];
      end
    end
    return r;
  endfunction

  // Greedy pick: scanning upward lets the highest eligible denomination win.
  always_comb begin
    sel_found_s = 1'b0;
    sel_idx_s   = 3'd0;
    for (int k = 0; k < 6; k++) begin
      if ((coin_value(3'(k)) <= pend_q) && (stock_q[4*k +: 4] != 4'd0)) begin
        sel_found_s = 1'b1;
        sel_idx_s   = 3'(k);
      end else begin
        sel_found_s = sel_found_s;
        sel_idx_s   = sel_idx_s;
      end
    end
  end

  // Next-state and next-output logic; pulses default low, everything else holds.
  always_comb begin
    state_d  = state_q;
    ejeta_d  = 1'b0;
    pronto_d = 1'b0;
    tipo_d   = tipo_q;
    devol_d  = devol_q;
    pend_d   = pend_q;
    ocup_d   = ocup_q;
    ok_d     = ok_q;
    falha_d  = falha_q;
    stock_d  = stock_q;
    case (state_q)
      S_IDLE: begin
        if (dar_troco) begin
          pend_d  = valor_troco;
          stock_d = moedas_carteira;
          devol_d = 24'd0;
          ok_d    = 1'b0;
          falha_d = 1'b0;
          ocup_d  = 1'b1;
          state_d = S_SELECT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SELECT: begin
        if (pend_q == 8'd0) begin
          ok_d     = 1'b1;
          pronto_d = 1'b1;
          state_d  = S_DONE;
        end else if (sel_found_s) begin
          tipo_d  = sel_idx_s;
          ejeta_d = 1'b1;
          state_d = S_EJECT;
        end else begin
          falha_d  = 1'b1;
          pronto_d = 1'b1;
          state_d  = S_DONE;
        end
      end
      S_EJECT: begin
        // SELECT guaranteed the coin fits, so this never wraps.
        pend_d  = pend_q - coin_value(tipo_q);
        stock_d = field_step(stock_q, tipo_q, 1'b0);
        devol_d = field_step(devol_q, tipo_q, 1'b1);
        state_d = S_SELECT;
      end
      S_DONE: begin
        ocup_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        ocup_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any transaction without a pulse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      ejeta_q  <= 1'b0;
      tipo_q   <= 3'd0;
      devol_q  <= 24'd0;
      pend_q   <= 8'd0;
      ocup_q   <= 1'b0;
      pronto_q <= 1'b0;
      ok_q     <= 1'b0;
      falha_q  <= 1'b0;
      stock_q  <= 24'd0;
    end else begin
      state_q  <= state_d;
      ejeta_q  <= ejeta_d;
      tipo_q   <= tipo_d;
      devol_q  <= devol_d;
      pend_q   <= pend_d;
      ocup_q   <= ocup_d;
      pronto_q <= pronto_d;
      ok_q     <= ok_d;
      falha_q  <= falha_d;
      stock_q  <= stock_d;
    end
  end

  assign ejeta_moeda       = ejeta_q;
  assign tipo_moeda        = tipo_q;
  assign moedas_devolvidas = devol_q;
  assign valor_pendente    = pend_q;
  assign ocupado           = ocup_q;
  assign troco_pronto      = pronto_q;
  assign troco_ok          = ok_q;
  assign troco_falha       = falha_q;

endmodule

// File: tb/tb_dispensador_troco.sv
`timescale 1ns/1ps
// Self-checking bench for dispensador_troco: a transaction-level greedy model
// predicts each coin, the completion cycle and the final status, and a
// negedge compare process checks every output on every cycle.
module tb_dispensador_troco;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        dar_troco = 1'b0;
  logic [7:0]  valor_troco = 8'd0;
  logic [23:0] moedas_carteira = 24'd0;
  logic        ejeta_moeda;
  logic [2:0]  tipo_moeda;
  logic [23:0] moedas_devolvidas;
  logic [7:0]  valor_pendente;
  logic        ocupado;
  logic        troco_pronto;
  logic        troco_ok;
  logic        troco_falha;

  always #5 clock = ~clock;

  dispensador_troco dut (
    .clock             (clock),
    .reset             (reset),
    .dar_troco         (dar_troco),
    .valor_troco       (valor_troco),
    .moedas_carteira   (moedas_carteira),
    .ejeta_moeda       (ejeta_moeda),
    .tipo_moeda        (tipo_moeda),
    .moedas_devolvidas (moedas_devolvidas),
    .valor_pendente    (valor_pendente),
    .ocupado           (ocupado),
    .troco_pronto      (troco_pronto),
    .troco_ok          (troco_ok),
    .troco_falha       (troco_falha)
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Transaction outcome computed straight from the greedy rule.
  typedef struct packed {
    logic [7:0]        n;
    logic [95:0][2:0]  coins;
    logic [7:0]        pend;
    logic [23:0]       devol;
    logic              ok;
  } res_t;

  function automatic res_t greedy(input logic [7:0] valor, input logic [23:0] stock);
    int   vals[6] = '{1, 5, 10, 25, 50, 100};
    res_t r;
    int   pend;
    int   stk[6];
    int   best;
    logic stuck;
    r = '0;
    pend = int'(valor);
    stuck = 1'b0;
    for (int k = 0; k < 6; k++) stk[k] = int'(stock[4*k +: 4]);
    for (int it = 0; it < 96; it++) begin
      if (pend != 0 && !stuck) begin
        best = -1;
        for (int k = 0; k < 6; k++)
          if (vals[k] <= pend && stk[k] > 0) best = k;
        if (best >= 0) begin
          r.coins[r.n] = best[2:0];
          r.n = r.n + 8'd1;
          pend = pend - vals[best];
          stk[best] = stk[best] - 1;
          r.devol[4*best +: 4] = r.devol[4*best +: 4] + 4'd1;
        end else begin
          stuck = 1'b1;
        end
      end
    end
    r.pend = pend[7:0];
    r.ok   = (pend == 0);
    return r;
  endfunction

  // Model state: cur_d is the cycle offset from the acceptance edge.
  res_t        m = '0;
  logic        busy_m = 1'b0;
  int          cur_d = 0;
  logic        m_ok = 1'b0, m_falha = 1'b0;
  logic [7:0]  m_pend = 8'd0;
  logic [23:0] m_devol = 24'd0;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      busy_m  <= 1'b0;
      cur_d   <= 0;
      m_ok    <= 1'b0;
      m_falha <= 1'b0;
      m_pend  <= 8'd0;
      m_devol <= 24'd0;
    end else if (!busy_m) begin
      if (dar_troco) begin
        m       <= greedy(valor_troco, moedas_carteira);
        busy_m  <= 1'b1;
        cur_d   <= 1;
        m_ok    <= 1'b0;
        m_falha <= 1'b0;
      end
    end else begin
      if (cur_d == 2*int'(m.n) + 2) busy_m <= 1'b0;
      else cur_d <= cur_d + 1;
      if (cur_d == 2*int'(m.n) + 1) begin
        m_ok    <= m.ok;
        m_falha <= !m.ok;
        m_pend  <= m.pend;
        m_devol <= m.devol;
      end
    end
  end

  int   last;
  logic e_ej;
  logic in_flight;

  always @(negedge clock) begin
    if (chk_en) begin
      last      = 2*int'(m.n) + 2;
      e_ej      = busy_m && (cur_d % 2 == 0) && (cur_d < last);
      in_flight = busy_m && (cur_d < last);
      check("ejeta_moeda", 32'(ejeta_moeda), 32'(e_ej));
      if (e_ej) check("tipo_moeda", 32'(tipo_moeda), 32'(m.coins[cur_d/2 - 1]));
      check("troco_pronto", 32'(troco_pronto), 32'(busy_m && cur_d == last));
      check("ocupado", 32'(ocupado), 32'(busy_m));
      check("troco_ok", 32'(troco_ok), in_flight ? 32'd0 : 32'(m_ok));
      check("troco_falha", 32'(troco_falha), in_flight ? 32'd0 : 32'(m_falha));
      if (!in_flight) begin
        check("valor_pendente", 32'(valor_pendente), 32'(m_pend));
        check("moedas_devolvidas", 32'(moedas_devolvidas), 32'(m_devol));
      end
    end
  end

  logic [2:0] ej_seq[$];
  int         lat;

  function automatic logic [31:0] seq_pack();
    logic [31:0] r;
    r = 32'd0;
    foreach (ej_seq[i]) r = (r << 3) | 32'(ej_seq[i]);
    return r;
  endfunction

  // One request; lat ends as the completion cycle offset from acceptance.
  task automatic run_req(input logic [7:0] v, input logic [23:0] s,
                         input int poke_at, input int chg_at);
    @(negedge clock);
    dar_troco = 1'b1;
    valor_troco = v;
    moedas_carteira = s;
    @(negedge clock);
    dar_troco = 1'b0;
    lat = 1;
    ej_seq.delete();
    while (troco_pronto !== 1'b1 && lat < 300) begin
      if (ejeta_moeda === 1'b1) ej_seq.push_back(tipo_moeda);
      if (lat == poke_at) begin
        dar_troco = 1'b1;
        valor_troco = 8'($urandom);
      end else begin
        dar_troco = 1'b0;
      end
      if (lat == chg_at) moedas_carteira = 24'd0;
      @(negedge clock);
      lat++;
    end
    dar_troco = 1'b0;
    if (lat >= 300) check("timeout", 32'd0, 32'd1);
  endtask

  int pulses;
  logic [23:0] rs;

  initial begin
    repeat (3) @(negedge clock);
    chk_en = 1'b1;
    check("reset_ocupado", 32'(ocupado), 32'd0);
    check("reset_devol", 32'(moedas_devolvidas), 32'd0);
    reset = 1'b0;

    // 65 from stock all 2: 50, 10, 5
    run_req(8'd65, 24'h222222, -1, -1);
    check("t65_lat", 32'(lat), 32'd8);
    check("t65_n", 32'(ej_seq.size()), 32'd3);
    check("t65_seq", seq_pack(), 32'({3'd4, 3'd2, 3'd1}));
    check("t65_devol", 32'(moedas_devolvidas), 32'h010110);
    check("t65_ok", 32'(troco_ok), 32'd1);
    check("t65_pend", 32'(valor_pendente), 32'd0);

    // zero amount
    run_req(8'd0, 24'h222222, -1, -1);
    check("t0_lat", 32'(lat), 32'd2);
    check("t0_n", 32'(ej_seq.size()), 32'd0);
    check("t0_ok", 32'(troco_ok), 32'd1);

    // shortfall: 3 with two 1-coins
    run_req(8'd3, 24'h000002, -1, -1);
    check("t3_lat", 32'(lat), 32'd6);
    check("t3_seq", seq_pack(), 32'({3'd0, 3'd0}));
    check("t3_falha", 32'(troco_falha), 32'd1);
    check("t3_ok", 32'(troco_ok), 32'd0);
    check("t3_pend", 32'(valor_pendente), 32'd1);

    // greedy shortfall 30 with only a 25
    run_req(8'd30, 24'h001000, -1, -1);
    check("t30_seq", seq_pack(), 32'(3'd3));
    check("t30_pend", 32'(valor_pendente), 32'd5);
    check("t30_falha", 32'(troco_falha), 32'd1);

    // 255 with full stock, plus an ignored request while busy
    run_req(8'd255, 24'hFFFFFF, 3, -1);
    check("t255_lat", 32'(lat), 32'd10);
    check("t255_seq", seq_pack(), 32'({3'd5, 3'd5, 3'd4, 3'd1}));
    check("t255_devol", 32'(moedas_devolvidas), 32'h210010);
    check("t255_ok", 32'(troco_ok), 32'd1);
    pulses = 0;
    repeat (8) begin
      @(negedge clock);
      if (troco_pronto === 1'b1) pulses++;
    end
    check("t255_single_pronto", 32'(pulses), 32'd0);

    // reset in the first EJECT cycle
    @(negedge clock);
    dar_troco = 1'b1;
    valor_troco = 8'd200;
    moedas_carteira = 24'h200000;
    @(negedge clock);
    dar_troco = 1'b0;
    @(posedge clock);
    #1;
    check("rst_pre_ejeta", 32'(ejeta_moeda), 32'd1);
    check("rst_pre_tipo", 32'(tipo_moeda), 32'd5);
    reset = 1'b1;
    #1;
    check("rst_ejeta", 32'(ejeta_moeda), 32'd0);
    check("rst_ocupado", 32'(ocupado), 32'd0);
    check("rst_pend", 32'(valor_pendente), 32'd0);
    check("rst_tipo", 32'(tipo_moeda), 32'd0);
    check("rst_pronto", 32'(troco_pronto), 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    run_req(8'd200, 24'h120000, -1, -1);
    check("rst_new_lat", 32'(lat), 32'd8);
    check("rst_new_seq", seq_pack(), 32'({3'd5, 3'd4, 3'd4}));
    check("rst_new_ok", 32'(troco_ok), 32'd1);

    // snapshot survives a change of moedas_carteira
    run_req(8'd10, 24'h000100, -1, 1);
    check("snap_lat", 32'(lat), 32'd4);
    check("snap_seq", seq_pack(), 32'(3'd2));
    check("snap_ok", 32'(troco_ok), 32'd1);

    // randomized transactions
    for (int i = 0; i < 40; i++) begin
      rs = 24'd0;
      for (int k = 0; k < 6; k++)
        rs[4*k +: 4] = (i % 2 == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 2));
      run_req(8'($urandom_range(0, 255)), rs,
              int'($urandom_range(1, 4)), int'($urandom_range(1, 6)));
      check("rand_lat", 32'(lat), 32'(2*int'(m.n) + 2));
      check("rand_n", 32'(ej_seq.size()), 32'(m.n));
      repeat ($urandom_range(0, 3)) @(negedge clock);
    end

    repeat (3) @(negedge clock);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
